// File: rtl/led_scan_scheduler.sv
// Four-digit seven-segment scan controller: blanked anode multiplexing, hex window decode, debounced scroll.
// Outputs are registered; a scroll request waits for the next frame boundary so a frame never shows two offsets.
module led_scan_scheduler #(
  parameter int DIGIT_CYCLES    = 16,
  parameter int BLANK_CYCLES    = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        button,
  input  logic [63:0] msg,
  output logic        an3,
  output logic        an2,
  output logic        an1,
  output logic        an0,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        f,
  output logic        g,
  output logic        dp,
  output logic [3:0]  offset
);

  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       slot_q, slot_d;
  logic [3:0]       offset_q, offset_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             rise;
  logic             wrap;
  logic             frame_end;
  logic             load;
  logic [3:0]       idx;
  logic [3:0]       nib;

  // Active-low abcdefg pattern for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_comb begin
    sync1_d  = button;
    sync2_d  = sync1_q;
    db_d     = db_q;
    db_cnt_d = '0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    rise = ~db_q & db_d;

    wrap      = (cnt_q == CNT_LAST);
    frame_end = wrap && (slot_q == 2'd0);
    cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    slot_d    = wrap ? slot_q - 2'd1 : slot_q;

    // A rise landing on the boundary cycle itself survives into the next frame.
    offset_d  = offset_q + {3'b000, frame_end & pending_q};
    pending_d = frame_end ? rise : (pending_q | rise);

    // The cnt_q==0 term covers the very first slot after reset.
    load = (cnt_d == '0) || (cnt_q == '0);
    idx  = offset_d + 4'd3 - {2'b00, slot_d};
    nib  = msg[{idx, 2'b00} +: 4];

    seg_d = load ? hex7(nib) : seg_q;
    dp_d  = load ? ~((slot_d == 2'd3) && (offset_d == 4'd0)) : dp_q;
    an_d  = (cnt_d < CNT_BLANK) ? 4'hF : ~(4'b0001 << slot_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_cnt_q  <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      slot_q    <= 2'd3;
      offset_q  <= 4'd0;
      an_q      <= 4'hF;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_cnt_q  <= db_cnt_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      offset_q  <= offset_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an3 = an_q[3];
  assign an2 = an_q[2];
  assign an1 = an_q[1];
  assign an0 = an_q[0];
  assign {a, b, c, d, e, f, g} = seg_q;
  assign dp     = dp_q;
  assign offset = offset_q;

endmodule

// File: tb/tb_led_scan_scheduler.sv
// Scoreboard bench for led_scan_scheduler: expected offsets queued per press, display checked per frame.
module tb_led_scan_scheduler;

  logic        clk;
  logic        reset;
  logic        button;
  logic [63:0] msg;
  logic        an3, an2, an1, an0;
  logic        a, b, c, d, e, f, g;
  logic        dp;
  logic [3:0]  offset;

  int          vectors;
  int          miscompares;
  int          cyc;
  bit          started;
  logic [3:0]  last_off;
  logic [3:0]  model_off;
  logic [3:0]  exp_q[$];

  led_scan_scheduler dut (
    .clk(clk), .reset(reset), .button(button), .msg(msg),
    .an3(an3), .an2(an2), .an1(an1), .an0(an0),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .dp(dp), .offset(offset)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    logic [6:0] t [16];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
          7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
          7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return t[h];
  endfunction

  // Anode pattern every cycle, and every offset change popped against the queue.
  always @(negedge clk) begin
    if (started && reset) begin
      int k, s;
      logic [3:0] exp_an;
      k = cyc % 16;
      s = 3 - ((cyc / 16) % 4);
      exp_an = (k < 2) ? 4'hF : ~(4'b0001 << s);
      chk("anodes", {28'd0, an3, an2, an1, an0}, {28'd0, exp_an});
      if (offset !== last_off) begin
        if (exp_q.size() == 0) begin
          chk("spurious_advance", {28'd0, offset}, {28'd0, last_off});
        end else begin
          chk("offset_step", {28'd0, offset}, {28'd0, exp_q.pop_front()});
        end
        chk("advance_phase", cyc % 64, 0);
        last_off = offset;
      end
    end else begin
      last_off = 4'd0;
    end
  end

  task automatic wait_phase(input int ph);
    bit found;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (cyc % 64 == ph) found = 1;
    end
    if (!found) chk("phase_timeout", 0, 1);
  endtask

  task automatic check_frame(input logic [3:0] eo);
    wait_phase(0);
    for (int i = 0; i < 64; i++) begin
      int k, s;
      logic [3:0] ch;
      k  = cyc % 16;
      s  = 3 - ((cyc / 16) % 4);
      ch = 4'((int'(eo) + 3 - s) & 15);
      if (k == 1 || k == 8 || k == 15) begin
        chk("segments", {25'd0, a, b, c, d, e, f, g}, {25'd0, seg_of(msg[4*ch +: 4])});
        chk("dp", {31'd0, dp}, {31'd0, ~((s == 3) && (eo == 4'd0))});
        chk("offset_hold", {28'd0, offset}, {28'd0, eo});
      end
      @(negedge clk);
    end
  endtask

  task automatic press(input int hi, input int lo, input bit counts);
    if (counts) begin
      model_off = model_off + 4'd1;
      exp_q.push_back(model_off);
    end
    @(posedge clk); #1 button = 1'b1;
    repeat (hi) @(posedge clk);
    #1 button = 1'b0;
    repeat (lo) @(posedge clk);
  endtask

  initial begin
    vectors = 0; miscompares = 0; started = 0; model_off = 4'd0;
    reset = 1'b0; button = 1'b0; msg = 64'hFEDCBA9876543210;
    #100;
    chk("reset_anodes", {28'd0, an3, an2, an1, an0}, 32'hF);
    chk("reset_segments", {25'd0, a, b, c, d, e, f, g}, 32'h7F);
    chk("reset_dp", {31'd0, dp}, 32'd1);
    chk("reset_offset", {28'd0, offset}, 32'd0);
    @(negedge clk); reset = 1'b1; started = 1;
    check_frame(4'd0);

    press(32, 288, 1);
    check_frame(4'd1);

    press(3, 320, 0);
    check_frame(4'd1);

    for (int v = 2; v <= 16; v++) begin
      press(32, 288, 1);
      if (v == 13) check_frame(4'd13);
    end
    check_frame(4'd0);

    wait_phase(2);
    model_off = model_off + 4'd1;
    exp_q.push_back(model_off);
    button = 1'b1; repeat (6) @(negedge clk);
    button = 1'b0; repeat (6) @(negedge clk);
    button = 1'b1; repeat (6) @(negedge clk);
    button = 1'b0; repeat (200) @(negedge clk);
    check_frame(4'd1);

    for (int v = 0; v < 4; v++) press(32, 288, 1);
    check_frame(4'd5);

    wait_phase(23);
    #2 reset = 1'b0;
    #1;
    chk("midreset_anodes", {28'd0, an3, an2, an1, an0}, 32'hF);
    chk("midreset_segments", {25'd0, a, b, c, d, e, f, g}, 32'h7F);
    chk("midreset_dp", {31'd0, dp}, 32'd1);
    chk("midreset_offset", {28'd0, offset}, 32'd0);
    model_off = 4'd0;
    #100;
    @(negedge clk); reset = 1'b1;
    check_frame(4'd0);

    repeat (70) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
